program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot stage directly upstream of the CPU core; owns the core's reset and its 32x8 program memory port until a program image is loaded.
- Accepts a byte stream (length byte, then program bytes) over a valid/ready handshake and writes the bytes to memory addresses 0..N-1.
- Then releases the core from reset, counts run cycles until the core raises halt, and reports completion.

Parameters:
- DATA_WIDTH, 8, memory word / stream byte width
- ADDR_WIDTH, 5, memory address width; maximum image length is 2**ADDR_WIDTH = 32
- CYC_WIDTH, 16, run-cycle counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load
- byte_valid  in  1  stream byte present
- byte_data  in  DATA_WIDTH  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- mem_sel  out  1  1 = loader owns the memory port (top-level mux select)
- mem_addr  out  ADDR_WIDTH  memory write address
- mem_data  out  DATA_WIDTH  memory write data
- mem_wr  out  1  memory write strobe, one cycle
- cpu_rst  out  1  active-low reset to the core
- halt  in  1  core halt flag
- busy  out  1  loading or running
- done  out  1  core halted after a successful run
- error  out  1  bad image
- run_cycles  out  CYC_WIDTH  clock cycles with cpu_rst high before halt

Behaviour:
- Reset (rst low, asynchronous) puts the block in IDLE. All of the following clear to 0: byte_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, error, run_cycles. mem_sel = 1.
- States: IDLE, LEN, LOAD, RUN, HALTED, ERROR.
- Handshake: accept = byte_valid & byte_ready. byte_ready = 1 only in LEN and LOAD; it is decoded from the state register and does not depend on byte_valid.
- IDLE: on start, go to LEN. Clear run_cycles, error and done.
- LEN: on accept, latch N = byte_data.
  - N == 0 or N > 32: go to ERROR.
  - Otherwise: clear the address counter, go to LOAD.
- LOAD: on each accept, register mem_addr = counter and mem_data = byte_data. mem_wr is high the following cycle, for exactly one cycle. Increment the counter.
  - When the N-th byte is accepted, go to RUN. The final write strobe happens in the first RUN cycle.
  - A byte_valid gap leaves the state unchanged.
- RUN:
  - mem_sel = 0 from the cycle after the final mem_wr; cpu_rst = 1 from that same cycle.
  - run_cycles increments each cycle cpu_rst is high and saturates at all-ones.
  - When halt == 1 is sampled, go to HALTED. run_cycles freezes at that value; cpu_rst stays high so the core remains halted.
- HALTED: done = 1, busy = 0.
- ERROR: error = 1, cpu_rst = 0, mem_sel = 1.
- start in HALTED or ERROR: go to LEN. cpu_rst drops to 0 in the same cycle as the transition; done and error clear.
- start in LEN, LOAD or RUN: ignored.
- busy = 1 in LEN, LOAD and RUN.
- cpu_rst is 0 in every state except RUN and HALTED.
- halt is ignored outside RUN.
- Address counter is ADDR_WIDTH+1 bits wide. N == 32 writes addresses 0..31 with no wrap.
- rst mid-LOAD: outputs clear immediately. Memory contents already written are undefined for the next run.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: after the N data bytes, LOAD accepts one extra checksum byte. The checksum is the sum of the N data bytes modulo 2**DATA_WIDTH.
  - Match: go to RUN.
  - Mismatch: go to ERROR; the core is never released.
  - No mem_wr is issued for the checksum byte.
- Not defined: no checksum byte. The transition to RUN follows the N-th data byte directly.

Test Plan:
- Assert rst low mid-stream, then release -> all outputs at reset values, state IDLE, byte_ready = 0, cpu_rst = 0.
- start; stream 0x03, 0xA1, 0x22, 0xE3 with byte_valid held high -> mem_wr pulses at addresses 0, 1, 2 with data A1, 22, E3; cpu_rst rises the cycle after the last pulse; busy = 1.
- Continue the previous run; drive halt = 1 on the 10th cycle that cpu_rst is high -> done = 1, run_cycles = 10, cpu_rst stays 1.
- start; stream length byte 0x00 (then repeat with 0x21) -> error = 1, no mem_wr, cpu_rst = 0; a further start clears error and returns to LEN.
- N = 32 with byte_valid toggling every other cycle -> 32 writes at addresses 0..31, no wrap, RUN entered once; start pulses during LOAD and RUN are ignored.
- With LOADER_CHECKSUM_EN defined: stream 0x02, 0x10, 0x20, 0x30 -> RUN. Stream 0x02, 0x10, 0x20, 0x31 -> ERROR, cpu_rst = 0, two mem_wr pulses only.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: streams an image into program memory, releases and times the core.
// Optional LOADER_CHECKSUM_EN: a trailing checksum byte gates the core release.
module program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CYC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wr,
  output logic                  cpu_rst,
  input  logic                  halt,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CYC_WIDTH-1:0]  run_cycles
);

  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int MAX_LEN = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [CYC_WIDTH-1:0] CYC_ONE = CYC_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_RUN,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  logic accept;
  logic len_ok;

  assign byte_ready = (state_q == S_LEN) || (state_q == S_LOAD);
  assign accept     = byte_valid && byte_ready;
  assign len_ok     = (byte_data != '0) && (int'(byte_data) <= MAX_LEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      cpu_rst_q <= 1'b0;
      cyc_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      cpu_rst_q <= cpu_rst_d;
      cyc_q     <= cyc_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    cpu_rst_d = 1'b0;
    cyc_d     = cyc_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN;
          cyc_d   = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d = CNT_W'(byte_data);
          if (len_ok) begin
            cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = S_LOAD;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (cnt_q == len_q) begin
            state_d = (byte_data == sum_q) ? S_RUN : S_ERROR;
          end else begin
            addr_d = cnt_q[ADDR_WIDTH-1:0];
            data_d = byte_data;
            wr_d   = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
            sum_d  = sum_q + byte_data;
          end
`else
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          data_d = byte_data;
          wr_d   = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_d == len_q) begin
            state_d = S_RUN;
          end
`endif
        end
      end
      S_RUN: begin
        // First RUN cycle keeps the core in reset while the last write lands.
        cpu_rst_d = 1'b1;
        if (cpu_rst_q) begin
          if (cyc_q != '1) begin
            cyc_d = cyc_q + CYC_ONE;
          end
          if (halt) begin
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        cpu_rst_d = 1'b1;
        if (start) begin
          state_d   = S_LEN;
          cpu_rst_d = 1'b0;
          cyc_d     = '0;
        end
      end
      S_ERROR: begin
        if (start) begin
          state_d = S_LEN;
          cyc_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_sel    = ~cpu_rst_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_wr     = wr_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_RUN);
  assign done       = (state_q == S_HALTED);
  assign error      = (state_q == S_ERROR);
  assign run_cycles = cyc_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader with a write scoreboard.
module tb_program_loader;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_RISE = 1'b0;
`else
  localparam bit CHK_RISE = 1'b1;
`endif

  typedef logic [DW-1:0] bq_t [$];
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          start      = 1'b0;
  logic          byte_valid = 1'b0;
  logic          halt       = 1'b0;
  logic [DW-1:0] byte_data  = '0;
  logic          byte_ready, mem_sel, mem_wr, cpu_rst, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [CW-1:0] run_cycles;

  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   wr_seen     = 0;
  int   last_wr_cyc = 0;
  int   rise_cnt    = 0;
  int   rise_cyc    = 0;
  logic prev_cpu_rst = 1'b0;
  wr_t  exp_wr [$];
  wr_t  mon_e;

  program_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CYC_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wr    (mem_wr),
    .cpu_rst   (cpu_rst),
    .halt      (halt),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst) begin
      if (mem_wr) begin
        wr_seen++;
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wr: write addr %0d data 0x%0h, none expected", mem_addr, mem_data);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
          check("wr_data", 32'(mem_data), 32'(mon_e.d));
        end
      end
      if (cpu_rst && !prev_cpu_rst) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      check("mem_sel_vs_cpu_rst", 32'(mem_sel), 32'(!cpu_rst));
      check("ready_implies_busy", 32'(byte_ready && !busy), 0);
      check("error_holds_core", 32'(error && cpu_rst), 0);
      check("done_not_busy", 32'(done && busy), 0);
      check("wr_core_in_reset", 32'(mem_wr && cpu_rst), 0);
    end
    prev_cpu_rst = cpu_rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"},   32'(byte_ready), 0);
    check({name, "_mem_wr"},  32'(mem_wr), 0);
    check({name, "_addr"},    32'(mem_addr), 0);
    check({name, "_data"},    32'(mem_data), 0);
    check({name, "_cpu_rst"}, 32'(cpu_rst), 0);
    check({name, "_busy"},    32'(busy), 0);
    check({name, "_done"},    32'(done), 0);
    check({name, "_error"},   32'(error), 0);
    check({name, "_cycles"},  32'(run_cycles), 0);
    check({name, "_mem_sel"}, 32'(mem_sel), 1);
  endtask

  // gap: 0 valid held high, 1 valid toggles each cycle, 2 random valid.
  task automatic send_bytes(input bq_t bytes, input int gap, input bit noise);
    int idx = 0;
    int budget = 0;
    bit tog = 1'b1;
    bit acc;
    while (idx < bytes.size() && budget < 400) begin
      byte_valid = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
      tog        = ~tog;
      byte_data  = byte_valid ? bytes[idx] : DW'($urandom);
      start      = noise && ($urandom_range(0, 5) == 0);
      at_neg();
      acc = byte_valid && byte_ready;
      tick();
      if (acc) idx++;
      budget++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check("stream_accepted", idx, bytes.size());
  endtask

  task automatic run_and_halt(input int k, input bit chk_rise);
    int w = 0;
    at_neg();
    while (!cpu_rst && w < 20) begin
      at_neg();
      w++;
    end
    check("cpu_rst_rise", 32'(cpu_rst), 1);
    if (chk_rise) check("rise_after_last_wr", rise_cyc, last_wr_cyc + 1);
    check("busy_in_run", 32'(busy), 1);
    check("mem_sel_in_run", 32'(mem_sel), 0);
    for (int i = 1; i < k; i++) begin
      start = (i == 2);
      at_neg();
    end
    start = 1'b0;
    halt  = 1'b1;
    tick();
    halt  = 1'b0;
    at_neg();
    check("halt_done", 32'(done), 1);
    check("halt_busy", 32'(busy), 0);
    check("halt_cpu_rst", 32'(cpu_rst), 1);
    check("halt_error", 32'(error), 0);
    check("halt_run_cycles", 32'(run_cycles), k);
    repeat (3) at_neg();
    check("frozen_run_cycles", 32'(run_cycles), k);
    check("frozen_done", 32'(done), 1);
    check("frozen_cpu_rst", 32'(cpu_rst), 1);
    tick();
  endtask

  task automatic run_ok(input bq_t data, input int gap, input bit noise, input int k);
    bq_t s;
    logic [DW-1:0] sum;
    wr_t e;
    int w0, r0;
    w0  = wr_seen;
    r0  = rise_cnt;
    sum = '0;
    s.push_back(DW'(data.size()));
    foreach (data[i]) begin
      s.push_back(data[i]);
      sum += data[i];
      e.a = AW'(i);
      e.d = data[i];
      exp_wr.push_back(e);
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(sum);
`endif
    pulse_start();
    at_neg();
    check("len_ready", 32'(byte_ready), 1);
    check("len_busy", 32'(busy), 1);
    check("len_cpu_rst", 32'(cpu_rst), 0);
    check("len_done", 32'(done), 0);
    check("len_error", 32'(error), 0);
    check("len_cycles_clear", 32'(run_cycles), 0);
    tick();
    send_bytes(s, gap, noise);
    run_and_halt(k, CHK_RISE);
    check("wr_count", wr_seen - w0, data.size());
    check("wr_queue_drained", exp_wr.size(), 0);
    check("run_entered_once", rise_cnt - r0, 1);
  endtask

  task automatic run_error(input logic [DW-1:0] len);
    bq_t s;
    int w0;
    w0 = wr_seen;
    pulse_start();
    at_neg();
    check("errlen_ready", 32'(byte_ready), 1);
    tick();
    s.push_back(len);
    halt = 1'b1;
    send_bytes(s, 0, 1'b0);
    at_neg();
    check("err_flag", 32'(error), 1);
    check("err_ready", 32'(byte_ready), 0);
    check("err_cpu_rst", 32'(cpu_rst), 0);
    check("err_busy", 32'(busy), 0);
    check("err_done", 32'(done), 0);
    check("err_mem_sel", 32'(mem_sel), 1);
    repeat (3) begin
      byte_valid = 1'b1;
      at_neg();
      check("err_no_ready", 32'(byte_ready), 0);
    end
    byte_valid = 1'b0;
    halt       = 1'b0;
    check("err_no_wr", wr_seen - w0, 0);
    tick();
    pulse_start();
    at_neg();
    check("err_cleared", 32'(error), 0);
    check("err_back_to_len", 32'(byte_ready), 1);
    check("err_restart_busy", 32'(busy), 1);
    tick();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic run_bad_sum();
    bq_t s;
    wr_t e;
    int w0;
    w0 = wr_seen;
    s.push_back(8'h02);
    s.push_back(8'h10);
    s.push_back(8'h20);
    s.push_back(8'h31);
    e.a = 0; e.d = 8'h10; exp_wr.push_back(e);
    e.a = 1; e.d = 8'h20; exp_wr.push_back(e);
    pulse_start();
    send_bytes(s, 0, 1'b0);
    at_neg();
    check("sum_bad_error", 32'(error), 1);
    check("sum_bad_cpu_rst", 32'(cpu_rst), 0);
    repeat (5) at_neg();
    check("sum_bad_never_released", 32'(cpu_rst), 0);
    check("sum_bad_two_writes", wr_seen - w0, 2);
    check("sum_bad_queue", exp_wr.size(), 0);
    tick();
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t d;
    wr_t e;
    int n;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    check_reset_vals("after_release");

    // Reset in the middle of a load.
    pulse_start();
    d.delete();
    d.push_back(8'h06);
    d.push_back(8'h11);
    d.push_back(8'h22);
    d.push_back(8'h33);
    for (int i = 0; i < 3; i++) begin
      e.a = AW'(i);
      e.d = d[i + 1];
      exp_wr.push_back(e);
    end
    send_bytes(d, 0, 1'b0);
    at_neg();
    check("midload_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check_reset_vals("mid_load_reset");
    check("midload_writes_seen", exp_wr.size(), 0);
    exp_wr.delete();
    tick();
    #3 rst = 1'b1;
    tick();
    check_reset_vals("idle_after_reset");

    // Directed image, run for exactly 10 released cycles.
    d.delete();
    d.push_back(8'hA1);
    d.push_back(8'h22);
    d.push_back(8'hE3);
    run_ok(d, 0, 1'b0, 10);
    check("lit_run_cycles_10", 32'(run_cycles), 32'd10);
    check("lit_done_after_run", 32'(done), 1);

    run_error(8'h00);
    run_error(8'h21);

    // Full 32-byte image with gaps and stray start pulses.
    d.delete();
    for (int i = 0; i < 32; i++) d.push_back(DW'($urandom));
    run_ok(d, 1, 1'b1, $urandom_range(3, 25));

`ifdef LOADER_CHECKSUM_EN
    d.delete();
    d.push_back(8'h10);
    d.push_back(8'h20);
    run_ok(d, 0, 1'b0, 4);
    check("lit_sum_run_cycles", 32'(run_cycles), 32'd4);
    run_bad_sum();
`endif

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        run_error(($urandom_range(0, 1) == 0) ? 8'h00 : DW'($urandom_range(33, 255)));
      end else begin
        n = $urandom_range(1, 32);
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(DW'($urandom));
        run_ok(d, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(3, 30));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
